rng_arbiter: RTL and testbench

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rng_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// ---------------------------------------------------------------------------
// rng_arbiter
//
// Shares a single XNOR-feedback LFSR between two requesters. A granted
// requester waits while the LFSR is advanced STEPS times. The resulting word
// is then presented on rnd_data, and rnd_valid pulses for one cycle. Grants
// are issued round-robin over a one-bit last-served pointer.
//
// Parameters
//   WIDTH         LFSR / random word width in bits (must be >= 8)
//   STEPS         LFSR shifts per draw, 1..255
//   DEFAULT_SEED  reset value and replacement for an all-ones seed
//
// Ports
//   FPGA_CLK1_50  in   1      sole clock, rising edge
//   rst           in   1      synchronous active-high reset
//   seed          in   WIDTH  reseed value, sampled when seed_load is accepted
//   seed_load     in   1      reseed request pulse, honoured only in IDLE
//   req           in   2      level draw requests, bit i = requester i
//   gnt           out  2      registered one-hot grant, zero when idle
//   rnd_data      out  WIDTH  registered random word, holds between draws
//   rnd_valid     out  1      one-cycle strobe qualifying rnd_data
//   busy          out  1      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module rng_arbiter #(
    parameter int               WIDTH        = 14,
    parameter int               STEPS        = 14,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 14'h0001
) (
    input  logic             FPGA_CLK1_50,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    output logic             busy
);

    // Counter is sized to hold STEPS itself, so it never wraps within a draw.
    localparam int               CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] lfsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_r;
    logic [1:0]       gnt_r;
    logic [WIDTH-1:0] rnd_data_r;
    logic             rnd_valid_r;
    logic             busy_r;

    logic [WIDTH-1:0] lfsr_next_s;
    logic [WIDTH-1:0] seed_fix_s;
    logic             win_s;
    logic [1:0]       win_onehot_s;

    // One XNOR-feedback shift. The all-ones word is this LFSR's lockup state.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
        logic fb;
        fb = ~(q[7] ^ q[2]);
        return {q[WIDTH-2:0], fb};
    endfunction

    // Next LFSR value and lockup-safe seed.
    always_comb begin
        lfsr_next_s = lfsr_step(lfsr_r);
        if (seed == ALL_ONES) begin
            seed_fix_s = DEFAULT_SEED;
        end else begin
            seed_fix_s = seed;
        end
    end

    // Round-robin pick: a lone requester wins; on contention the requester
    // that was not served last wins.
    always_comb begin
        win_s = 1'b0;
        case (req)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
        if (win_s) begin
            win_onehot_s = 2'b10;
        end else begin
            win_onehot_s = 2'b01;
        end
    end

    // Draw FSM with all outputs registered alongside the state.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= DEFAULT_SEED;
            cnt_r       <= '0;
            last_r      <= 1'b1;
            gnt_r       <= 2'b00;
            rnd_data_r  <= '0;
            rnd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rnd_valid_r <= 1'b0;
                    if (seed_load) begin
                        // Reseeding wins over requests; no grant this cycle.
                        lfsr_r <= seed_fix_s;
                        gnt_r  <= 2'b00;
                    end else if (req != 2'b00) begin
                        gnt_r   <= win_onehot_s;
                        last_r  <= win_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_STEP;
                    end else begin
                        gnt_r <= 2'b00;
                    end
                end
                ST_STEP: begin
                    lfsr_r <= lfsr_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        rnd_data_r  <= lfsr_next_s;
                        rnd_valid_r <= 1'b1;
                        state_r     <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    rnd_valid_r <= 1'b0;
                    gnt_r       <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    rnd_valid_r <= 1'b0;
                    gnt_r       <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign rnd_data  = rnd_data_r;
    assign rnd_valid = rnd_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_arbiter
//
// Two instances are used: one with STEPS=1 and one with STEPS=14. Inputs are
// shared. The instance that is not selected is held in reset, and sel picks
// which instance's outputs are observed. Expected values come from a small
// model: an LFSR value advanced by the shift rule, and a last-served
// requester.
// ---------------------------------------------------------------------------
module tb_rng_arbiter;

    logic        clk;
    logic        rst1;
    logic        rst14;
    logic [13:0] seed;
    logic        seed_load;
    logic [1:0]  req;
    logic        sel;

    logic [1:0]  gnt1;
    logic [1:0]  gnt14;
    logic [13:0] data1;
    logic [13:0] data14;
    logic        valid1;
    logic        valid14;
    logic        busy1;
    logic        busy14;

    logic [1:0]  gnt;
    logic [13:0] rnd_data;
    logic        rnd_valid;
    logic        busy;

    int          checks;
    int          errors;
    logic [13:0] m_lfsr;
    logic        m_last;

    rng_arbiter #(.STEPS(1)) dut1 (
        .FPGA_CLK1_50 (clk),
        .rst          (rst1),
        .seed         (seed),
        .seed_load    (seed_load),
        .req          (req),
        .gnt          (gnt1),
        .rnd_data     (data1),
        .rnd_valid    (valid1),
        .busy         (busy1)
    );

    rng_arbiter #(.STEPS(14)) dut14 (
        .FPGA_CLK1_50 (clk),
        .rst          (rst14),
        .seed         (seed),
        .seed_load    (seed_load),
        .req          (req),
        .gnt          (gnt14),
        .rnd_data     (data14),
        .rnd_valid    (valid14),
        .busy         (busy14)
    );

    assign gnt       = sel ? gnt14   : gnt1;
    assign rnd_data  = sel ? data14  : data1;
    assign rnd_valid = sel ? valid14 : valid1;
    assign busy      = sel ? busy14  : busy1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model LFSR n times using the XNOR feedback rule.
    function automatic logic [13:0] advance(input logic [13:0] v, input int n);
        logic [13:0] x;
        x = v;
        for (int i = 0; i < n; i++) begin
            x = {x[12:0], ~(x[7] ^ x[2])};
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 14'h0001;
        m_last = 1'b1;
    endtask

    // Seed load in IDLE, optionally alongside a request (seed load wins).
    task automatic load_seed(input logic [13:0] s, input logic [1:0] r);
        seed      = s;
        seed_load = 1'b1;
        req       = r;
        tick();
        seed_load = 1'b0;
        check("seed_gnt", 32'(gnt), 32'(2'b00));
        check("seed_busy", 32'(busy), 32'(1'b0));
        m_lfsr = (s == 14'h3FFF) ? 14'h0001 : s;
    endtask

    task automatic idle_cycle();
        req = 2'b00;
        tick();
        check("idle_gnt", 32'(gnt), 32'(2'b00));
        check("idle_busy", 32'(busy), 32'(1'b0));
        check("idle_valid", 32'(rnd_valid), 32'(1'b0));
    endtask

    // One full draw starting from IDLE. drop releases req after the grant,
    // and busy_load pulses seed_load mid-draw; the model ignores that pulse.
    task automatic do_draw(input logic [1:0] r, input bit drop, input bit busy_load);
        int          n;
        logic        w;
        logic [1:0]  exp_g;
        logic [13:0] exp_d;
        n = sel ? 14 : 1;
        if (r == 2'b01)      w = 1'b0;
        else if (r == 2'b10) w = 1'b1;
        else                 w = ~m_last;
        exp_g = w ? 2'b10 : 2'b01;
        req = r;
        tick();
        check("grant", 32'(gnt), 32'(exp_g));
        check("busy_e0", 32'(busy), 32'(1'b1));
        check("valid_e0", 32'(rnd_valid), 32'(1'b0));
        m_last = w;
        if (drop) req = 2'b00;
        if (busy_load) begin
            seed      = 14'($urandom);
            seed_load = 1'b1;
        end
        for (int k = 1; k < n; k++) begin
            tick();
            seed_load = 1'b0;
            check("gnt_hold", 32'(gnt), 32'(exp_g));
            check("valid_low", 32'(rnd_valid), 32'(1'b0));
        end
        tick();
        seed_load = 1'b0;
        exp_d  = advance(m_lfsr, n);
        m_lfsr = exp_d;
        check("valid_hi", 32'(rnd_valid), 32'(1'b1));
        check("data", 32'(rnd_data), 32'(exp_d));
        check("gnt_deliver", 32'(gnt), 32'(exp_g));
        tick();
        check("valid_end", 32'(rnd_valid), 32'(1'b0));
        check("gnt_end", 32'(gnt), 32'(2'b00));
        check("busy_end", 32'(busy), 32'(1'b0));
        check("data_hold", 32'(rnd_data), 32'(exp_d));
    endtask

    task automatic random_phase(input int n);
        int          act;
        logic [1:0]  r;
        logic [13:0] s;
        for (int i = 0; i < n; i++) begin
            act = int'($urandom_range(0, 3));
            r   = 2'($urandom_range(1, 3));
            if (act == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
                load_seed(s, 2'($urandom_range(0, 3)));
                do_draw(r, 1'($urandom_range(0, 1)), 1'b0);
            end else if (act == 1) begin
                idle_cycle();
            end else begin
                do_draw(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 1'b0;
        rst1      = 1'b1;
        rst14     = 1'b1;
        req       = 2'b00;
        seed      = 14'h0000;
        seed_load = 1'b0;
        model_reset();
        repeat (3) tick();

        // STEPS=1 instance
        rst1 = 1'b0;
        check("rst_gnt", 32'(gnt), 32'(2'b00));
        check("rst_valid", 32'(rnd_valid), 32'(1'b0));
        check("rst_data", 32'(rnd_data), 32'(14'h0000));
        check("rst_busy", 32'(busy), 32'(1'b0));
        do_draw(2'b01, 1'b1, 1'b0);
        check("first_word", 32'(rnd_data), 32'(14'h0003));
        do_draw(2'b01, 1'b1, 1'b0);
        check("second_word", 32'(rnd_data), 32'(14'h0007));
        load_seed(14'h3FFF, 2'b00);
        do_draw(2'b01, 1'b0, 1'b0);
        check("lockup_word", 32'(rnd_data), 32'(14'h0003));
        load_seed(14'h1234, 2'b01);
        do_draw(2'b01, 1'b1, 1'b0);
        do_draw(2'b10, 1'b0, 1'b1);
        random_phase(25);

        // STEPS=14 instance
        rst1  = 1'b1;
        sel   = 1'b1;
        rst14 = 1'b0;
        req   = 2'b00;
        model_reset();
        check("rst14_busy", 32'(busy), 32'(1'b0));
        for (int i = 0; i < 4; i++) begin
            do_draw(2'b11, 1'b0, 1'b0);
        end
        req = 2'b00;
        // Reset at the third step edge of a draw aborts it with no strobe.
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        rst14 = 1'b1;
        tick();
        rst14 = 1'b0;
        model_reset();
        check("abort_gnt", 32'(gnt), 32'(2'b00));
        check("abort_busy", 32'(busy), 32'(1'b0));
        check("abort_valid", 32'(rnd_valid), 32'(1'b0));
        for (int i = 0; i < 14; i++) begin
            idle_cycle();
        end
        do_draw(2'b11, 1'b0, 1'b0);
        do_draw(2'b01, 1'b1, 1'b1);
        random_phase(15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
